// File: rtl/card_authorizer_if.sv
// rtl/card_authorizer_if.sv - card authorizer signal bundle
//
// Groups the card, cost, vend and top-up inputs and the authorization
// outputs of card_authorizer. The slave modport is the authorizer; the
// master modport is the card reader / vending controller side.
// Optional macro CARD_TXN_COUNT_EN adds TXN_COUNT and DECLINE_COUNT.
//
// Signals:
//   CARD_IN     card inserted (level)
//   CARD_ID     card identity, sampled on CARD_IN rising edge
//   COST        price request, 0 = none
//   VEND        dispensing, rising edge commits debit
//   TOPUP       one-cycle top-up pulse, TOPUP_AMT added to CARD_ID
//   VALID_TRAN  authorization granted
//   DECLINED    authorization refused
//   BUSY        authorizer not idle
//   BALANCE     balance of the latched card, 0 when idle
interface card_authorizer_if #(
  parameter int NUM_CARDS = 8
);
  localparam int IDW = $clog2(NUM_CARDS);

  logic           CARD_IN;
  logic [IDW-1:0] CARD_ID;
  logic [2:0]     COST;
  logic           VEND;
  logic           TOPUP;
  logic [7:0]     TOPUP_AMT;
  logic           VALID_TRAN;
  logic           DECLINED;
  logic           BUSY;
  logic [7:0]     BALANCE;

`ifdef CARD_TXN_COUNT_EN
  logic [7:0]     TXN_COUNT;
  logic [7:0]     DECLINE_COUNT;

  modport master (
    output CARD_IN, CARD_ID, COST, VEND, TOPUP, TOPUP_AMT,
    input  VALID_TRAN, DECLINED, BUSY, BALANCE, TXN_COUNT, DECLINE_COUNT
  );

  modport slave (
    input  CARD_IN, CARD_ID, COST, VEND, TOPUP, TOPUP_AMT,
    output VALID_TRAN, DECLINED, BUSY, BALANCE, TXN_COUNT, DECLINE_COUNT
  );
`else
  modport master (
    output CARD_IN, CARD_ID, COST, VEND, TOPUP, TOPUP_AMT,
    input  VALID_TRAN, DECLINED, BUSY, BALANCE
  );

  modport slave (
    input  CARD_IN, CARD_ID, COST, VEND, TOPUP, TOPUP_AMT,
    output VALID_TRAN, DECLINED, BUSY, BALANCE
  );
`endif
endinterface

// File: rtl/card_authorizer.sv
// rtl/card_authorizer.sv - per-card balance table answering vend cost requests
//
// Ports:
//   CLK      system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   bus      card_authorizer_if slave modport (card, cost, vend, top-up in;
//            VALID_TRAN, DECLINED, BUSY, BALANCE out)
// Optional macro CARD_TXN_COUNT_EN adds committed-debit and decline counters.
//
// All outputs are registered from the next state, so they change on the
// same edge the FSM moves.
module card_authorizer #(
  parameter int         NUM_CARDS     = 8,
  parameter logic [7:0] INIT_BALANCE  = 8'd20,
  parameter int         AUTH_LATENCY  = 3,
  parameter int         GRANT_TIMEOUT = 12
) (
  input logic              CLK,
  input logic              RESET_N,
  card_authorizer_if.slave bus
);
  localparam int IDW   = $clog2(NUM_CARDS);
  localparam int NSLOT = 1 << IDW;
  localparam int TW    = $clog2(GRANT_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_COST, AUTH, GRANT, DENY, DONE} state_t;

  state_t         state, state_nxt;
  logic [7:0]     acct [NSLOT];
  logic [IDW-1:0] card_q, card_nxt;
  logic [2:0]     cost_q, cost_nxt;
  logic [2:0]     auth_cnt, auth_cnt_nxt;
  logic [TW-1:0]  grant_cnt, grant_cnt_nxt;
  logic           card_in_q, vend_q;
  logic           card_rise, vend_rise;
  logic           wr_en;
  logic [IDW-1:0] wr_idx;
  logic [7:0]     wr_val;
  logic [8:0]     topup_sum;
  logic [7:0]     cur_bal, bal_nxt;
  logic           valid_tran_q, declined_q, busy_q;
  logic [7:0]     balance_q;

  assign card_rise = bus.CARD_IN & ~card_in_q;
  assign vend_rise = bus.VEND & ~vend_q;
  assign topup_sum = {1'b0, acct[bus.CARD_ID]} + {1'b0, bus.TOPUP_AMT};
  // Slots beyond NUM_CARDS read as empty, so such cards are always declined.
  assign cur_bal   = (int'(card_q) < NUM_CARDS) ? acct[card_q] : 8'd0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    card_nxt      = card_q;
    cost_nxt      = cost_q;
    auth_cnt_nxt  = auth_cnt;
    grant_cnt_nxt = grant_cnt;
    wr_en         = 1'b0;
    wr_idx        = bus.CARD_ID;
    wr_val        = topup_sum[8] ? 8'hFF : topup_sum[7:0];
    case (state)
      IDLE: begin
        // Card insertion beats a same-cycle top-up.
        if (card_rise) begin
          card_nxt  = bus.CARD_ID;
          state_nxt = WAIT_COST;
        end else if (bus.TOPUP && !bus.CARD_IN && (int'(bus.CARD_ID) < NUM_CARDS)) begin
          wr_en = 1'b1;
        end
      end
      WAIT_COST: begin
        if (!bus.CARD_IN) begin
          state_nxt = IDLE;
        end else if (bus.COST != 3'd0) begin
          cost_nxt     = bus.COST;
          auth_cnt_nxt = 3'd0;
          state_nxt    = AUTH;
        end
      end
      AUTH: begin
        if (!bus.CARD_IN) begin
          state_nxt = IDLE;
        end else if (auth_cnt == 3'(AUTH_LATENCY - 1)) begin
          if (cur_bal >= {5'd0, cost_q}) begin
            grant_cnt_nxt = '0;
            state_nxt     = GRANT;
          end else begin
            state_nxt = DENY;
          end
        end else begin
          auth_cnt_nxt = auth_cnt + 3'd1;
        end
      end
      GRANT: begin
        // A vend edge is checked before the timeout so the debit wins a tie.
        if (vend_rise) begin
          wr_en     = 1'b1;
          wr_idx    = card_q;
          wr_val    = cur_bal - {5'd0, cost_q};
          state_nxt = DONE;
        end else if (grant_cnt == TW'(GRANT_TIMEOUT - 1)) begin
          state_nxt = DONE;
        end else begin
          grant_cnt_nxt = grant_cnt + 1'b1;
        end
      end
      DENY: begin
        if (!bus.CARD_IN || bus.COST == 3'd0) state_nxt = DONE;
      end
      DONE: begin
        if (!bus.CARD_IN && bus.COST == 3'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Balance as it will read after this edge, including a same-edge debit.
    if (int'(card_nxt) >= NUM_CARDS)            bal_nxt = 8'd0;
    else if (wr_en && wr_idx == card_nxt)       bal_nxt = wr_val;
    else                                        bal_nxt = acct[card_nxt];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      card_q       <= '0;
      cost_q       <= '0;
      auth_cnt     <= '0;
      grant_cnt    <= '0;
      card_in_q    <= 1'b0;
      vend_q       <= 1'b0;
      valid_tran_q <= 1'b0;
      declined_q   <= 1'b0;
      busy_q       <= 1'b0;
      balance_q    <= 8'd0;
      for (int i = 0; i < NSLOT; i++) acct[i] <= INIT_BALANCE;
    end else begin
      card_q       <= card_nxt;
      cost_q       <= cost_nxt;
      auth_cnt     <= auth_cnt_nxt;
      grant_cnt    <= grant_cnt_nxt;
      card_in_q    <= bus.CARD_IN;
      vend_q       <= bus.VEND;
      valid_tran_q <= (state_nxt == GRANT);
      declined_q   <= (state_nxt == DENY);
      busy_q       <= (state_nxt != IDLE);
      balance_q    <= (state_nxt == IDLE) ? 8'd0 : bal_nxt;
      if (wr_en) acct[wr_idx] <= wr_val;
    end
  end

  assign bus.VALID_TRAN = valid_tran_q;
  assign bus.DECLINED   = declined_q;
  assign bus.BUSY       = busy_q;
  assign bus.BALANCE    = balance_q;

`ifdef CARD_TXN_COUNT_EN
  logic [7:0] txn_count_q, decline_count_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      txn_count_q     <= 8'd0;
      decline_count_q <= 8'd0;
    end else begin
      if (state == GRANT && vend_rise)    txn_count_q     <= txn_count_q + 8'd1;
      if (state == AUTH && state_nxt == DENY) decline_count_q <= decline_count_q + 8'd1;
    end
  end

  assign bus.TXN_COUNT     = txn_count_q;
  assign bus.DECLINE_COUNT = decline_count_q;
`endif
endmodule

// File: tb/tb_card_authorizer.sv
// tb/tb_card_authorizer.sv - self-checking bench for card_authorizer
module tb_card_authorizer;
  localparam int NUM_CARDS     = 8;
  localparam int AUTH_LATENCY  = 3;
  localparam int GRANT_TIMEOUT = 12;
  localparam int INIT_BAL      = 20;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   model_bal [NUM_CARDS];
  int   model_txn;
  int   model_dec;

  card_authorizer_if #(.NUM_CARDS(NUM_CARDS)) bus ();

  card_authorizer #(
    .NUM_CARDS    (NUM_CARDS),
    .INIT_BALANCE (8'd20),
    .AUTH_LATENCY (AUTH_LATENCY),
    .GRANT_TIMEOUT(GRANT_TIMEOUT)
  ) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NUM_CARDS; i++) model_bal[i] = INIT_BAL;
    model_txn = 0;
    model_dec = 0;
  endtask

  task automatic topup(input logic [2:0] c, input logic [7:0] amt);
    @(negedge clk);
    bus.CARD_ID   = c;
    bus.TOPUP_AMT = amt;
    bus.TOPUP     = 1'b1;
    @(negedge clk);
    bus.TOPUP     = 1'b0;
    model_bal[c]  = (model_bal[c] + int'(amt) > 255) ? 255 : model_bal[c] + int'(amt);
  endtask

  task automatic peek(input logic [2:0] c, output logic [7:0] b);
    @(negedge clk);
    bus.CARD_ID = c;
    bus.CARD_IN = 1'b1;
    bus.COST    = 3'd0;
    @(negedge clk);
    b = bus.BALANCE;
    bus.CARD_IN = 1'b0;
    @(negedge clk);
  endtask

  // Runs one purchase and reports what the authorizer did.
  task automatic do_txn(input logic [2:0] card, input logic [2:0] cost, input bit vend,
                        output bit granted, output bit declined, output int lat,
                        output logic [7:0] bal_seen, output logic [7:0] bal_after,
                        output logic valid_after, output int hi_cycles,
                        output logic [7:0] bal_final);
    @(negedge clk);
    bus.CARD_ID = card;
    bus.CARD_IN = 1'b1;
    bus.COST    = cost;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(bus.VALID_TRAN || bus.DECLINED) && lat < 40);
    granted     = bus.VALID_TRAN;
    declined    = bus.DECLINED;
    bal_seen    = bus.BALANCE;
    bal_after   = bal_seen;
    bal_final   = bal_seen;
    valid_after = 1'b0;
    hi_cycles   = 0;
    if (granted && vend) begin
      bus.VEND = 1'b1;
      @(negedge clk);
      bus.VEND    = 1'b0;
      valid_after = bus.VALID_TRAN;
      bal_after   = bus.BALANCE;
      @(negedge clk);
      bus.VEND = 1'b1;
      @(negedge clk);
      bus.VEND = 1'b0;
      @(negedge clk);
      bal_final = bus.BALANCE;
    end else if (granted) begin
      hi_cycles = 1;
      while (bus.VALID_TRAN && hi_cycles < 40) begin
        @(negedge clk);
        if (bus.VALID_TRAN) hi_cycles++;
      end
      bal_after = bus.BALANCE;
      bal_final = bal_after;
    end else if (declined) begin
      @(negedge clk);
      valid_after = bus.VALID_TRAN;
    end
    bus.CARD_IN = 1'b0;
    bus.COST    = 3'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.VALID_TRAN !== 1'b0 || bus.DECLINED !== 1'b0 || bus.BUSY !== 1'b0 || bus.BALANCE !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vt=%b dec=%b busy=%b bal=%0d want all 0",
               bus.VALID_TRAN, bus.DECLINED, bus.BUSY, bus.BALANCE);
    end
  endtask

  task automatic test_grant_latency();
    bit g, d; int lat, hi; logic [7:0] bs, ba, bf; logic va;
    do_txn(3'd2, 3'd3, 1'b1, g, d, lat, bs, ba, va, hi, bf);
    model_bal[2] -= 3;
    model_txn++;
    checks++;
    if (g !== 1'b1 || lat != AUTH_LATENCY + 2) begin
      errors++; $display("FAIL grant_latency: got granted=%0d lat=%0d want 1 lat=%0d", g, lat, AUTH_LATENCY + 2);
    end
    checks++;
    if (bs !== 8'd20) begin errors++; $display("FAIL grant_bal_before: got %0d want 20", bs); end
    checks++;
    if (ba !== 8'd17 || va !== 1'b0) begin
      errors++; $display("FAIL vend_debit: got bal=%0d vt=%b want bal=17 vt=0", ba, va);
    end
    checks++;
    if (bf !== 8'd17) begin errors++; $display("FAIL second_vend: got %0d want 17", bf); end
  endtask

  task automatic test_decline();
    bit g, d; int lat, hi; logic [7:0] bs, ba, bf, pk; logic va;
    for (int k = 0; k < 3; k++) begin
      do_txn(3'd5, 3'd6, 1'b1, g, d, lat, bs, ba, va, hi, bf);
      model_bal[5] -= 6;
      model_txn++;
      checks++;
      if (g !== 1'b1 || ba !== 8'(model_bal[5])) begin
        errors++; $display("FAIL drain_%0d: got granted=%0d bal=%0d want 1 bal=%0d", k, g, ba, model_bal[5]);
      end
    end
    do_txn(3'd5, 3'd4, 1'b1, g, d, lat, bs, ba, va, hi, bf);
    model_dec++;
    checks++;
    if (d !== 1'b1 || g !== 1'b0 || va !== 1'b0 || lat != AUTH_LATENCY + 2) begin
      errors++; $display("FAIL decline: got dec=%0d granted=%0d vt=%b lat=%0d want 1 0 0 %0d",
                         d, g, va, lat, AUTH_LATENCY + 2);
    end
    peek(3'd5, pk);
    checks++;
    if (pk !== 8'd2) begin errors++; $display("FAIL decline_bal: got %0d want 2", pk); end
  endtask

  task automatic test_timeout();
    bit g, d; int lat, hi; logic [7:0] bs, ba, bf, pk; logic va;
    do_txn(3'd1, 3'd5, 1'b0, g, d, lat, bs, ba, va, hi, bf);
    checks++;
    if (g !== 1'b1 || hi != GRANT_TIMEOUT) begin
      errors++; $display("FAIL timeout_len: got granted=%0d high=%0d want 1 high=%0d", g, hi, GRANT_TIMEOUT);
    end
    peek(3'd1, pk);
    checks++;
    if (pk !== 8'd20) begin errors++; $display("FAIL timeout_bal: got %0d want 20", pk); end
  endtask

  task automatic test_abort_and_topup();
    logic [7:0] pk;
    bit saw_vt;
    @(negedge clk);
    bus.CARD_ID = 3'd3;
    bus.CARD_IN = 1'b1;
    bus.COST    = 3'd2;
    saw_vt = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.VALID_TRAN) saw_vt = 1'b1;
    end
    checks++;
    if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", bus.BUSY); end
    bus.CARD_IN = 1'b0;
    @(negedge clk);
    bus.COST = 3'd0;
    checks++;
    if (bus.BUSY !== 1'b0 || saw_vt || bus.VALID_TRAN !== 1'b0) begin
      errors++; $display("FAIL abort_auth: got busy=%b vt_seen=%0d want busy=0 vt_seen=0", bus.BUSY, saw_vt);
    end
    // VEND outside GRANT must not debit.
    bus.VEND = 1'b1;
    @(negedge clk);
    bus.VEND = 1'b0;
    peek(3'd3, pk);
    checks++;
    if (pk !== 8'd20) begin errors++; $display("FAIL abort_bal: got %0d want 20", pk); end
    topup(3'd0, 8'd240);
    peek(3'd0, pk);
    checks++;
    if (pk !== 8'(model_bal[0])) begin errors++; $display("FAIL topup_sat_240: got %0d want %0d", pk, model_bal[0]); end
    topup(3'd4, 8'd230);
    topup(3'd4, 8'd10);
    peek(3'd4, pk);
    checks++;
    if (pk !== 8'd255) begin errors++; $display("FAIL topup_sat_250: got %0d want 255", pk); end
  endtask

  task automatic test_reset_in_grant();
    logic [7:0] pk;
    int w;
    @(negedge clk);
    bus.CARD_ID = 3'd6;
    bus.CARD_IN = 1'b1;
    bus.COST    = 3'd2;
    w = 0;
    while (!bus.VALID_TRAN && w < 40) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (bus.VALID_TRAN !== 1'b1) begin errors++; $display("FAIL rst_grant_reach: got %b want 1", bus.VALID_TRAN); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.VALID_TRAN !== 1'b0 || bus.BUSY !== 1'b0) begin
      errors++; $display("FAIL async_reset: got vt=%b busy=%b want 0 0", bus.VALID_TRAN, bus.BUSY);
    end
    bus.CARD_IN = 1'b0;
    bus.COST    = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    peek(3'd0, pk);
    checks++;
    if (pk !== 8'd20) begin errors++; $display("FAIL reset_restore_0: got %0d want 20", pk); end
    peek(3'd5, pk);
    checks++;
    if (pk !== 8'd20) begin errors++; $display("FAIL reset_restore_5: got %0d want 20", pk); end
  endtask

`ifdef CARD_TXN_COUNT_EN
  task automatic test_counters();
    bit g, d; int lat, hi; logic [7:0] bs, ba, bf; logic va;
    checks++;
    if (bus.TXN_COUNT !== 8'd0 || bus.DECLINE_COUNT !== 8'd0) begin
      errors++; $display("FAIL count_reset: got txn=%0d dec=%0d want 0 0", bus.TXN_COUNT, bus.DECLINE_COUNT);
    end
    for (int k = 0; k < 5; k++) begin
      logic [2:0] c;
      logic [2:0] cost;
      c    = (k == 2) ? 3'd1 : 3'd7;
      cost = (k == 2) ? 3'd1 : 3'd7;
      do_txn(c, cost, 1'b1, g, d, lat, bs, ba, va, hi, bf);
      if (model_bal[c] >= int'(cost)) begin
        model_bal[c] -= int'(cost);
        model_txn++;
      end else begin
        model_dec++;
      end
    end
    checks++;
    if (bus.TXN_COUNT !== 8'd3 || bus.DECLINE_COUNT !== 8'd2) begin
      errors++; $display("FAIL counters: got txn=%0d dec=%0d want 3 2", bus.TXN_COUNT, bus.DECLINE_COUNT);
    end
  endtask
`endif

  task automatic test_random();
    bit g, d, vend, exp_g; int lat, hi; logic [7:0] bs, ba, bf, pk; logic va;
    logic [2:0] c, cost;
    for (int n = 0; n < 40; n++) begin
      c = 3'($urandom_range(0, NUM_CARDS - 1));
      if ($urandom_range(0, 3) == 0) begin
        topup(c, 8'($urandom_range(0, 255)));
      end else begin
        cost  = 3'($urandom_range(1, 7));
        vend  = ($urandom_range(0, 3) != 0);
        exp_g = (model_bal[c] >= int'(cost));
        do_txn(c, cost, vend, g, d, lat, bs, ba, va, hi, bf);
        checks++;
        if (g !== exp_g || d !== !exp_g || lat != AUTH_LATENCY + 2 || bs !== 8'(model_bal[c])) begin
          errors++;
          $display("FAIL rand_auth[%0d]: card=%0d cost=%0d got g=%0d d=%0d lat=%0d bal=%0d want g=%0d bal=%0d",
                   n, c, cost, g, d, lat, bs, exp_g, model_bal[c]);
        end
        if (exp_g && vend) begin
          model_bal[c] -= int'(cost);
          model_txn++;
        end
        if (!exp_g) model_dec++;
        checks++;
        if (bf !== 8'(model_bal[c])) begin
          errors++; $display("FAIL rand_bal[%0d]: card=%0d got %0d want %0d", n, c, bf, model_bal[c]);
        end
      end
    end
    for (int i = 0; i < NUM_CARDS; i++) begin
      peek(3'(i), pk);
      checks++;
      if (pk !== 8'(model_bal[i])) begin
        errors++; $display("FAIL rand_final[%0d]: got %0d want %0d", i, pk, model_bal[i]);
      end
    end
`ifdef CARD_TXN_COUNT_EN
    checks++;
    if (bus.TXN_COUNT !== 8'(model_txn) || bus.DECLINE_COUNT !== 8'(model_dec)) begin
      errors++; $display("FAIL rand_counters: got txn=%0d dec=%0d want %0d %0d",
                         bus.TXN_COUNT, bus.DECLINE_COUNT, model_txn, model_dec);
    end
`endif
  endtask

  initial begin
    clk           = 1'b0;
    rst_n         = 1'b0;
    errors        = 0;
    checks        = 0;
    bus.CARD_IN   = 1'b0;
    bus.CARD_ID   = 3'd0;
    bus.COST      = 3'd0;
    bus.VEND      = 1'b0;
    bus.TOPUP     = 1'b0;
    bus.TOPUP_AMT = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_grant_latency();
    test_decline();
    test_timeout();
    test_abort_and_topup();
    test_reset_in_grant();
`ifdef CARD_TXN_COUNT_EN
    test_counters();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
